tod_bcd_sched: RTL and testbench

TOD_BCD_SCHED -- requirements
Module: tod_bcd_sched

---
 rtl/tod_bcd_sched_pkg.sv | 28 ++
 rtl/tod_bcd_sched_rr_arbiter.sv | 30 +++
 rtl/tod_bcd_sched.sv | 168 ++++++++++++++++
 tb/tb_tod_bcd_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tod_bcd_sched_pkg.sv
// Shared definitions for the BCD conversion scheduler: FSM encoding,
// error codes and the largest operand representable in the BCD result.
package tod_bcd_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      DONE,
      CLEAR,
      ERR
   } state_t;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_OVF = 2'b01;
   localparam logic [1:0] ERR_TMO = 2'b10;

   // 10^digits - 1: the largest value the converter can express
   function automatic logic [31:0] bcd_max(input int digits);
      logic [31:0] p;
      p = 32'd1;
      for (int i = 0; i < digits; i++) begin
         p = p * 32'd10;
      end
      return p - 32'd1;
   endfunction

endpackage

// File: rtl/tod_bcd_sched_rr_arbiter.sv
// Round-robin one-hot selector: lowest request at or above the pointer,
// otherwise wraps around to the lowest request overall.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] i_Req,
   input  logic [PTR_W-1:0] i_Ptr,
   output logic [N_REQ-1:0] o_Grant
);

   logic [N_REQ-1:0] w_Mask;
   logic [N_REQ-1:0] w_Masked;
   logic [N_REQ-1:0] w_Hi_Pick;
   logic [N_REQ-1:0] w_Lo_Pick;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_mask
         assign w_Mask[gi] = (PTR_W'(gi) >= i_Ptr);
      end
   endgenerate

   assign w_Masked  = i_Req & w_Mask;
   // x & -x isolates the lowest set bit
   assign w_Hi_Pick = w_Masked & (~w_Masked + N_REQ'(1));
   assign w_Lo_Pick = i_Req & (~i_Req + N_REQ'(1));
   assign o_Grant   = (|w_Masked) ? w_Hi_Pick : w_Lo_Pick;

endmodule

// File: rtl/tod_bcd_sched.sv
// Shares one external binary-to-BCD converter among N_REQ requesters,
// with overflow screening, a saturating timeout and converter resync.
module tod_bcd_sched #(
   parameter int N_REQ          = 4,
   parameter int INPUT_WIDTH    = 12,
   parameter int DECIMAL_DIGITS = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   input  logic [N_REQ-1:0]              i_Req,
   input  logic [N_REQ*INPUT_WIDTH-1:0]  i_Binary,
   output logic [N_REQ-1:0]              o_Grant,
   output logic [N_REQ-1:0]              o_Done,
   output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
   output logic [1:0]                    o_Err,
   output logic                          o_Conv_Start,
   output logic [INPUT_WIDTH-1:0]        o_Conv_Binary,
   input  logic [DECIMAL_DIGITS*4-1:0]   i_Conv_BCD,
   input  logic                          i_Conv_DV,
   output logic                          o_Conv_Clear
);
   import tod_bcd_sched_pkg::*;

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BCD_W = DECIMAL_DIGITS * 4;
   localparam logic [31:0]      MAX_VAL = bcd_max(DECIMAL_DIGITS);
   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);

   state_t                 r_State;
   logic                   r_Resync;
   logic [PTR_W-1:0]       r_Ptr;
   logic [PTR_W-1:0]       r_Idx;
   logic [CNT_W-1:0]       r_Count;
   logic [INPUT_WIDTH-1:0] r_Operand;
   logic [N_REQ-1:0]       r_Grant;
   logic [N_REQ-1:0]       r_Done;
   logic [BCD_W-1:0]       r_BCD;
   logic [1:0]             r_Err;
   logic                   r_Conv_Start;
   logic                   r_Conv_Clear;

   logic [N_REQ-1:0]       w_Arb_Grant;
   logic [PTR_W-1:0]       w_Arb_Idx;
   logic [PTR_W-1:0]       w_Next_Ptr;
   logic [INPUT_WIDTH-1:0] w_Arb_Operand;
   logic                   w_Ovf;
   logic [CNT_W-1:0]       w_Count_Inc;
   logic                   w_Timeout;
   logic [N_REQ-1:0]       w_Idx_Onehot;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .i_Req   (i_Req),
      .i_Ptr   (r_Ptr),
      .o_Grant (w_Arb_Grant)
   );

   always_comb begin
      w_Arb_Idx     = '0;
      w_Arb_Operand = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_Arb_Grant[k]) begin
            w_Arb_Idx     = PTR_W'(k);
            w_Arb_Operand = i_Binary[k*INPUT_WIDTH +: INPUT_WIDTH];
         end
      end
   end

   assign w_Next_Ptr  = (w_Arb_Idx == PTR_W'(N_REQ - 1)) ? '0 : w_Arb_Idx + PTR_W'(1);
   assign w_Ovf       = (32'(w_Arb_Operand) > MAX_VAL);
   assign w_Count_Inc = (r_Count == '1) ? r_Count : r_Count + CNT_W'(1);
   assign w_Timeout   = (w_Count_Inc >= TMO_VAL);

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
         assign w_Idx_Onehot[gi] = (r_Idx == PTR_W'(gi));
      end
   endgenerate

   // Outputs are registered on the transition into the state that owns them
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_State      <= IDLE;
         r_Resync     <= 1'b1;
         r_Ptr        <= '0;
         r_Idx        <= '0;
         r_Count      <= '0;
         r_Operand    <= '0;
         r_Grant      <= '0;
         r_Done       <= '0;
         r_BCD        <= '0;
         r_Err        <= ERR_OK;
         r_Conv_Start <= 1'b0;
         r_Conv_Clear <= 1'b0;
      end else begin
         r_Grant      <= '0;
         r_Done       <= '0;
         r_Err        <= ERR_OK;
         r_Conv_Start <= 1'b0;
         r_Conv_Clear <= 1'b0;
         case (r_State)
            IDLE: begin
               if (r_Resync) begin
                  r_Resync     <= 1'b0;
                  r_Conv_Clear <= 1'b1;
                  r_State      <= CLEAR;
               end else if (|i_Req) begin
                  r_Grant   <= w_Arb_Grant;
                  r_Idx     <= w_Arb_Idx;
                  r_Operand <= w_Arb_Operand;
                  r_Ptr     <= w_Next_Ptr;
                  if (w_Ovf) begin
                     r_Done  <= w_Arb_Grant;
                     r_BCD   <= '1;
                     r_Err   <= ERR_OVF;
                     r_State <= ERR;
                  end else begin
                     r_Conv_Start <= 1'b1;
                     r_State      <= START;
                  end
               end
            end
            START: begin
               r_Count <= '0;
               r_State <= WAIT;
            end
            WAIT: begin
               r_Count <= w_Count_Inc;
               if (i_Conv_DV) begin
                  r_Done  <= w_Idx_Onehot;
                  r_BCD   <= i_Conv_BCD;
                  r_Err   <= ERR_OK;
                  r_State <= DONE;
               end else if (w_Timeout) begin
                  r_Done  <= w_Idx_Onehot;
                  r_BCD   <= '1;
                  r_Err   <= ERR_TMO;
                  r_State <= ERR;
               end
            end
            DONE, ERR: begin
               r_Conv_Clear <= 1'b1;
               r_State      <= CLEAR;
            end
            CLEAR: begin
               r_State <= IDLE;
            end
            default: begin
               r_State <= IDLE;
            end
         endcase
      end
   end

   assign o_Grant       = r_Grant;
   assign o_Done        = r_Done;
   assign o_BCD         = r_BCD;
   assign o_Err         = r_Err;
   assign o_Conv_Start  = r_Conv_Start;
   assign o_Conv_Binary = r_Operand;
   assign o_Conv_Clear  = r_Conv_Clear;

endmodule

// File: tb/tb_tod_bcd_sched.sv
// Directed bench for tod_bcd_sched with a behavioural converter whose
// response latency can be programmed or suppressed.
module tb_tod_bcd_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [47:0] bin;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic [11:0] bcd;
   logic [1:0]  err;
   logic        conv_start;
   logic [11:0] conv_bin;
   logic [11:0] conv_bcd;
   logic        conv_dv;
   logic        conv_clear;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int starts  = 0;
   int clears  = 0;
   int conv_lat   = 3;
   bit conv_never = 1'b0;

   tod_bcd_sched dut (
      .i_Clock       (clk),
      .i_Reset       (rst),
      .i_Req         (req),
      .i_Binary      (bin),
      .o_Grant       (grant),
      .o_Done        (done),
      .o_BCD         (bcd),
      .o_Err         (err),
      .o_Conv_Start  (conv_start),
      .o_Conv_Binary (conv_bin),
      .i_Conv_BCD    (conv_bcd),
      .i_Conv_DV     (conv_dv),
      .o_Conv_Clear  (conv_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] to_bcd(input logic [11:0] v);
      int x;
      logic [11:0] r;
      x = int'(v);
      r[3:0]  = 4'(x % 10);
      r[7:4]  = 4'((x / 10) % 10);
      r[11:8] = 4'((x / 100) % 10);
      return r;
   endfunction

   // Converter model and pulse monitor, updated 1 time unit after each edge
   initial begin
      int cnt;
      bit busy;
      cnt = 0;
      busy = 1'b0;
      conv_dv = 1'b0;
      conv_bcd = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (conv_start) starts++;
         if (conv_clear) clears++;
         if (conv_clear) begin
            conv_dv = 1'b0;
            busy = 1'b0;
         end else if (conv_start) begin
            busy = 1'b1;
            cnt = conv_lat;
         end else if (busy && !conv_dv && !conv_never) begin
            cnt--;
            if (cnt == 0) begin
               conv_bcd = to_bcd(conv_bin);
               conv_dv = 1'b1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_grant(input logic [3:0] exp, input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (grant == 4'b0 && n < 600);
      check(tag, 32'(grant), 32'(exp));
   endtask

   task automatic wait_done(input logic [3:0] exp_done, input logic [11:0] exp_bcd,
                            input logic [1:0] exp_err, input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (done == 4'b0 && n < 600);
      $display("txn %s: done=%b bcd=%h err=%b cycle=%0d", tag, done, bcd, err, cyc);
      check({tag, "_done"}, 32'(done), 32'(exp_done));
      check({tag, "_bcd"},  32'(bcd),  32'(exp_bcd));
      check({tag, "_err"},  32'(err),  32'(exp_err));
   endtask

   initial begin
      int s;
      int c0;
      int st0;
      int seen;
      logic [11:0] ops [4];
      logic [11:0] exps [4];

      rst = 1'b1;
      req = '0;
      bin = '0;
      repeat (3) step();
      check("rst_grant", 32'(grant), 0);
      check("rst_done",  32'(done), 0);
      check("rst_bcd",   32'(bcd), 0);
      check("rst_err",   32'(err), 0);
      check("rst_start", 32'(conv_start), 0);
      check("rst_clear", 32'(conv_clear), 0);

      // Release: one resync clear before anything else
      rst = 1'b0;
      step();
      check("resync_clear", 32'(conv_clear), 1);
      step();
      check("resync_clear_end", 32'(conv_clear), 0);

      // Single request, operand 255
      conv_lat = 3;
      bin[0 +: 12] = 12'd255;
      req = 4'b0001;
      c0 = clears;
      wait_grant(4'b0001, "s1_grant");
      check("s1_start", 32'(conv_start), 1);
      req = 4'b0000;
      wait_done(4'b0001, 12'h255, 2'b00, "s1");
      step();
      check("s1_clear", 32'(conv_clear), 1);
      check("s1_done_pulse", 32'(done), 0);
      check("s1_clear_count", 32'(clears - c0), 1);
      step();
      check("s1_bcd_hold", 32'(bcd), 32'h255);

      // Overflow on requester 2 (pointer now 1)
      bin[24 +: 12] = 12'd1000;
      req = 4'b0100;
      st0 = starts;
      wait_grant(4'b0100, "ovf_grant");
      req = 4'b0000;
      check("ovf_done", 32'(done), 32'b0100);
      check("ovf_bcd",  32'(bcd), 32'hFFF);
      check("ovf_err",  32'(err), 1);
      step();
      check("ovf_clear", 32'(conv_clear), 1);
      check("ovf_no_start", 32'(starts - st0), 0);

      // Timeout on requester 3 (pointer now 3)
      conv_never = 1'b1;
      bin[36 +: 12] = 12'd7;
      req = 4'b1000;
      wait_grant(4'b1000, "tmo_grant");
      s = cyc;
      req = 4'b0000;
      wait_done(4'b1000, 12'hFFF, 2'b10, "tmo");
      check("tmo_latency", 32'(cyc - s - 1), 255);
      step();
      check("tmo_clear", 32'(conv_clear), 1);
      conv_never = 1'b0;

      // All four requesting; pointer is back at 0
      ops[0] = 12'd1;   exps[0] = 12'h001;
      ops[1] = 12'd22;  exps[1] = 12'h022;
      ops[2] = 12'd333; exps[2] = 12'h333;
      ops[3] = 12'd999; exps[3] = 12'h999;
      for (int k = 0; k < 4; k++) bin[k*12 +: 12] = ops[k];
      conv_lat = 2;
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_grant(4'(1 << k), $sformatf("rr%0d_grant", k));
         req[k] = 1'b0;
         wait_done(4'(1 << k), exps[k], 2'b00, $sformatf("rr%0d", k));
      end

      // Pointer wrapped to 0: 1001 must pick 0, DV arriving on the timeout cycle wins
      bin[0 +: 12]  = 12'd777;
      bin[36 +: 12] = 12'd42;
      conv_lat = 255;
      req = 4'b1001;
      wait_grant(4'b0001, "wrap_grant");
      s = cyc;
      req[0] = 1'b0;
      wait_done(4'b0001, 12'h777, 2'b00, "dv_at_tmo");
      check("dv_at_tmo_latency", 32'(cyc - s), 256);

      // Reset during WAIT aborts; requester 3 still pending
      conv_lat = 50;
      wait_grant(4'b1000, "abort_grant");
      seen = 0;
      repeat (5) begin
         step();
         if (done != 4'b0) seen++;
      end
      rst = 1'b1;
      repeat (2) begin
         step();
         if (done != 4'b0) seen++;
      end
      rst = 1'b0;
      conv_lat = 3;
      step();
      if (done != 4'b0) seen++;
      check("abort_clear", 32'(conv_clear), 1);
      check("abort_no_done", 32'(seen), 0);
      wait_grant(4'b1000, "after_rst_grant");
      req = 4'b0000;
      wait_done(4'b1000, 12'h042, 2'b00, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
